// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path definitions: line geometry, the line controller state
// encoding and the default reset fetch address.
package riscv_fetch_pkg;

  localparam int ADDR_W        = 32;
  localparam int LINE_W        = 128;
  localparam int LINE_BYTES    = LINE_W / 8;
  localparam int LINE_OFF_BITS = $clog2(LINE_BYTES);
  localparam int WORD_OFF_BITS = LINE_OFF_BITS - 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // REQ: may issue a line read. WAIT: one read outstanding, waiting for data.
  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifetch_line_buf.sv
// Single-entry line holding register between the I-cache return path and the
// instruction queue. Load has priority over drain so a line captured in the
// same cycle the previous one leaves keeps the entry valid; clear beats both.
module ifetch_line_buf
  import riscv_fetch_pkg::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int PC_W   = ADDR_W,
  parameter int OFF_W  = WORD_OFF_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic [PC_W-1:0]   i_load_pc,
  input  logic [OFF_W-1:0]  i_load_off,
  input  logic              i_drain,
  input  logic              i_clear,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc,
  output logic [OFF_W-1:0]  o_off
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc_q;
  logic [OFF_W-1:0]  off_q;

  // Entry valid flag: clear (redirect) wins, then load, then drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
    end else if (i_drain) begin
      valid_q <= 1'b0;
    end
  end

  // Entry payload: written only on load so it stays stable while the queue is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      pc_q   <= '0;
      off_q  <= '0;
    end else if (i_load) begin
      data_q <= i_load_data;
      pc_q   <= i_load_pc;
      off_q  <= i_load_off;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_pc    = pc_q;
  assign o_off   = off_q;

endmodule

// File: rtl/ifetch_line_ctrl.sv
// Fetch-line controller: holds the fetch PC, keeps at most one line read in
// flight to the I-cache, buffers one returned line and pushes it into the
// instruction queue. Redirects flush the queue, retarget the PC and mark any
// in-flight read as stale so its data is dropped on return.
//
// Handshakes: a cache request transfers in a cycle where o_ic_req and
// i_ic_ready are both 1; o_ic_req never depends on i_ic_ready. A queue push
// happens in every cycle o_q_wen is 1, and o_q_wen is never raised while
// i_q_full is 1. Line data returns on i_ic_rvalid, in order, at least one
// cycle after the accepting cycle.
module ifetch_line_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int                  ADDR_WIDTH = ADDR_W,
  parameter int                  LINE_WIDTH = LINE_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_ic_req,
  output logic [ADDR_WIDTH-1:0] o_ic_addr,
  input  logic                  i_ic_ready,
  input  logic                  i_ic_rvalid,
  input  logic [LINE_WIDTH-1:0] i_ic_rdata,
  input  logic                  i_q_full,
  output logic                  o_q_wen,
  output logic [LINE_WIDTH-1:0] o_q_data,
  output logic                  o_q_flush,
  output logic [ADDR_WIDTH-1:0] o_line_pc,
  output logic [1:0]            o_line_off
);

  localparam int LOB    = $clog2(LINE_WIDTH / 8);
  localparam int LINE_N = ADDR_WIDTH - LOB;

  // Fetch PC is kept as a line number; the byte offset bits are always zero.
  fetch_state_t     state_q;
  logic [LINE_N-1:0] pc_line_q;
  logic [1:0]        off_q;
  logic              drop_q;

  logic              buf_valid;
  logic [LINE_WIDTH-1:0] buf_data;
  logic [ADDR_WIDTH-1:0] buf_pc;
  logic [1:0]        buf_off;

  logic              push;
  logic              req;
  logic              accept;
  logic              capture;
  logic [LINE_N-1:0] redirect_line;
  logic [1:0]        redirect_off;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic [1:0]        unused_redirect_bits;

  assign redirect_line        = i_redirect_pc[ADDR_WIDTH-1:LOB];
  assign redirect_off         = i_redirect_pc[LOB-1:2];
  assign unused_redirect_bits = i_redirect_pc[1:0];
  assign pc_addr              = {pc_line_q, {LOB{1'b0}}};

  // Push whenever a line is held, the queue has room and no redirect is flushing it.
  assign push = buf_valid & ~i_q_full & ~i_redirect;

  // A new read may go out only if its data is guaranteed a free buffer slot.
  assign req = (state_q == REQ) & (~buf_valid | push);

  assign accept = req & i_ic_ready;

  // Returned data is kept only if it answers a live request and no redirect lands now.
  assign capture = (state_q == WAIT) & i_ic_rvalid & ~drop_q & ~i_redirect;

  // Controller FSM, fetch PC, pending offset and stale-read drop flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= REQ;
      pc_line_q <= RESET_PC[ADDR_WIDTH-1:LOB];
      off_q     <= 2'b00;
      drop_q    <= 1'b0;
    end else if (i_redirect) begin
      pc_line_q <= redirect_line;
      off_q     <= redirect_off;
      case (state_q)
        REQ: begin
          if (accept) begin
            drop_q  <= 1'b1;
            state_q <= WAIT;
          end else begin
            state_q <= REQ;
          end
        end
        WAIT: begin
          if (i_ic_rvalid) begin
            // The outstanding read just returned; nothing left to drop.
            drop_q  <= 1'b0;
            state_q <= REQ;
          end else begin
            drop_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        default: state_q <= REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (accept) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (i_ic_rvalid) begin
            state_q <= REQ;
            if (drop_q) begin
              drop_q <= 1'b0;
            end else begin
              pc_line_q <= pc_line_q + 1'b1;
              off_q     <= 2'b00;
            end
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  ifetch_line_buf #(
    .DATA_W (LINE_WIDTH),
    .PC_W   (ADDR_WIDTH),
    .OFF_W  (2)
  ) u_line_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (capture),
    .i_load_data (i_ic_rdata),
    .i_load_pc   (pc_addr),
    .i_load_off  (off_q),
    .i_drain     (push),
    .i_clear     (i_redirect),
    .o_valid     (buf_valid),
    .o_data      (buf_data),
    .o_pc        (buf_pc),
    .o_off       (buf_off)
  );

  // Outputs are forced low while reset is held, including the combinational ones.
  always_comb begin
    o_ic_req   = 1'b0;
    o_ic_addr  = '0;
    o_q_wen    = 1'b0;
    o_q_data   = '0;
    o_q_flush  = 1'b0;
    o_line_pc  = '0;
    o_line_off = 2'b00;
    if (i_rst_n) begin
      o_ic_req   = req;
      o_ic_addr  = pc_addr;
      o_q_wen    = push;
      o_q_data   = buf_data;
      o_q_flush  = i_redirect;
      o_line_pc  = buf_pc;
      o_line_off = buf_off;
    end
  end

endmodule

// File: tb/tb_ifetch_line_ctrl.sv
// Directed bench for ifetch_line_ctrl: a cycle-by-cycle vector table for the
// fetch stream, queue back-pressure and redirect corner cases, followed by a
// hand-written asynchronous reset sequence.
module tb_ifetch_line_ctrl;

  logic          clk;
  logic          rst_n;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          ic_req;
  logic [31:0]   ic_addr;
  logic          ic_ready;
  logic          ic_rvalid;
  logic [127:0]  ic_rdata;
  logic          q_full;
  logic          q_wen;
  logic [127:0]  q_data;
  logic          q_flush;
  logic [31:0]   line_pc;
  logic [1:0]    line_off;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] raddr;
    logic        full;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ewen;
    logic        eflush;
    logic        chk;
    logic [31:0] elpc;
    logic [1:0]  eoff;
  } vec_t;

  vec_t tbl[$];

  ifetch_line_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_ic_req      (ic_req),
    .o_ic_addr     (ic_addr),
    .i_ic_ready    (ic_ready),
    .i_ic_rvalid   (ic_rvalid),
    .i_ic_rdata    (ic_rdata),
    .i_q_full      (q_full),
    .o_q_wen       (q_wen),
    .o_q_data      (q_data),
    .o_q_flush     (q_flush),
    .o_line_pc     (line_pc),
    .o_line_off    (line_off)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-tagged contents for every cache line.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a + 32'h4, a ^ 32'h5A5A_5A5A};
  endfunction

  function automatic vec_t v(input logic rd, input logic [31:0] rpc, input logic rdy,
                             input logic rv, input logic [31:0] raddr, input logic full,
                             input logic ereq, input logic [31:0] eaddr, input logic ewen,
                             input logic eflush, input logic chk, input logic [31:0] elpc,
                             input logic [1:0] eoff);
    vec_t t;
    t.rd = rd; t.rpc = rpc; t.rdy = rdy; t.rv = rv; t.raddr = raddr; t.full = full;
    t.ereq = ereq; t.eaddr = eaddr; t.ewen = ewen; t.eflush = eflush; t.chk = chk;
    t.elpc = elpc; t.eoff = eoff;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: inputs applied just after a falling edge.
  task automatic drive(input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] raddr, input logic full);
    redirect    = rd;
    redirect_pc = rpc;
    ic_ready    = rdy;
    ic_rvalid   = rv;
    ic_rdata    = rv ? line_of(raddr) : 128'h0;
    q_full      = full;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_row(input vec_t t, input int idx);
    drive(t.rd, t.rpc, t.rdy, t.rv, t.raddr, t.full);
    #1;
    check($sformatf("row%0d req", idx), {127'h0, ic_req}, {127'h0, t.ereq});
    if (t.ereq) check($sformatf("row%0d addr", idx), {96'h0, ic_addr}, {96'h0, t.eaddr});
    check($sformatf("row%0d wen", idx), {127'h0, q_wen}, {127'h0, t.ewen});
    check($sformatf("row%0d flush", idx), {127'h0, q_flush}, {127'h0, t.eflush});
    if (t.chk) begin
      check($sformatf("row%0d data", idx), q_data, line_of(t.elpc));
      check($sformatf("row%0d line_pc", idx), {96'h0, line_pc}, {96'h0, t.elpc});
      check($sformatf("row%0d line_off", idx), {126'h0, line_off}, {126'h0, t.eoff});
    end
    next_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"},   {127'h0, ic_req},   128'h0);
    check({tag, " addr"},  {96'h0, ic_addr},   128'h0);
    check({tag, " wen"},   {127'h0, q_wen},    128'h0);
    check({tag, " flush"}, {127'h0, q_flush},  128'h0);
    check({tag, " data"},  q_data,             128'h0);
    check({tag, " lpc"},   {96'h0, line_pc},   128'h0);
    check({tag, " off"},   {126'h0, line_off}, 128'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // rd rpc rdy rv raddr full | ereq eaddr ewen eflush chk elpc eoff
    // Sequential fetch, 1-cycle rvalid, queue never full
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0010, 1, 0, 1, 32'h0040_0000, 0));
    tbl.push_back(v(0, 0, 1, 1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0020, 1, 0, 1, 32'h0040_0010, 0));
    tbl.push_back(v(0, 0, 1, 1, 32'h0040_0020, 0, 0, 0, 0, 0, 0, 0, 0));
    // Queue full for 5 cycles with a buffered line, then a single push
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 0, 1, 0, 0, 1,          0, 0, 0, 0, 1, 32'h0040_0020, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0030, 1, 0, 1, 32'h0040_0020, 0));
    // Redirect while waiting; stale line returns 3 cycles later
    tbl.push_back(v(1, 32'h0040_0128, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0040_0030, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            1, 32'h0040_0120, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0120, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0040_0120, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0130, 1, 0, 1, 32'h0040_0120, 2));
    // Redirect in the same cycle as rvalid
    tbl.push_back(v(1, 32'h0040_0A44, 0, 1, 32'h0040_0130, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0040_0A40, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0040_0A40, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            1, 32'h0040_0A50, 1, 0, 1, 32'h0040_0A40, 1));
    // Redirect in the same cycle as request accept
    tbl.push_back(v(1, 32'h0050_0008, 1, 0, 0, 0, 1, 32'h0040_0A50, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0040_0A50, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0050_0000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0050_0000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            1, 32'h0050_0010, 1, 0, 1, 32'h0050_0000, 2));
    // Back-to-back redirects while a drop is pending; last target near the top of memory
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0050_0010, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h0060_0004, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 32'hFFFF_FFF4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h0050_0010, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0, 0));
    // PC wraps to zero
    tbl.push_back(v(0, 0, 1, 0, 0, 0,            1, 32'h0000_0000, 1, 0, 1, 32'hFFFF_FFF0, 1));
    tbl.push_back(v(0, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            1, 32'h0000_0010, 1, 0, 1, 32'h0000_0000, 0));
    // Redirect in REQ without accept
    tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 1, 32'h0000_0010, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,            1, 32'h0040_0000, 0, 0, 0, 0, 0));

    // Reset held: outputs low even with a redirect and cache traffic present
    @(negedge clk);
    drive(1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h0, 1'b0);
    #1;
    check_all_zero("reset");
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // Async reset in the middle of an outstanding read
    drive(1'b1, 32'h0070_000C, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("ar redirect flush", {127'h0, q_flush}, 128'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("ar req", {127'h0, ic_req}, 128'h1);
    check("ar addr", {96'h0, ic_addr}, {96'h0, 32'h0070_0000});
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("restart req", {127'h0, ic_req}, 128'h1);
    check("restart addr", {96'h0, ic_addr}, {96'h0, 32'h0040_0000});
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0000, 1'b0);
    #1;
    check("restart wait wen", {127'h0, q_wen}, 128'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("restart wen", {127'h0, q_wen}, 128'h1);
    check("restart data", q_data, line_of(32'h0040_0000));
    check("restart lpc", {96'h0, line_pc}, {96'h0, 32'h0040_0000});
    check("restart off", {126'h0, line_off}, 128'h0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
